// File: rtl/fp_exp_pkg.sv
// Shared definitions for the FP multiplier exponent/sign pipeline:
// flag bit positions, the packed flag record and an all-ones exponent helper.
package fp_exp_pkg;

  localparam int FLG_OVF  = 0;
  localparam int FLG_UNF  = 1;
  localparam int FLG_ZERO = 2;
  localparam int FLG_INF  = 3;
  localparam int FLG_NAN  = 4;
  localparam int NUM_FLG  = 5;

  // Field order matches the FLG_* indices when the struct is used as a vector.
  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic unf;
    logic ovf;
  } fp_flags_t;

  function automatic logic [31:0] exp_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_exp_classify.sv
// Combinational second-stage classification: debiases the exponent sum,
// resolves zero/inf/NaN operands and saturates over/underflow.
module fp_exp_classify
  import fp_exp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int BIAS  = 127
) (
  input  logic [EXP_W:0]   sum,
  input  logic             za,
  input  logic             zb,
  input  logic             ia,
  input  logic             ib,
  output logic [EXP_W-1:0] c_exp,
  output fp_flags_t        flags
);

  localparam logic [EXP_W-1:0]        EXP_ONES = EXP_W'(exp_max(EXP_W));
  localparam logic signed [EXP_W+1:0] E_BIAS   = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] E_OVF    = (EXP_W+2)'(exp_max(EXP_W));
  localparam logic signed [EXP_W+1:0] E_ZERO   = '0;

  logic signed [EXP_W+1:0] e;

  // Zero-extend before subtracting so the full sum range stays positive.
  assign e = $signed({1'b0, sum}) - E_BIAS;

  // e == 0 would need a denormal result, so it flushes with the negatives.
  function automatic logic [EXP_W-1:0] sat_exp(input logic signed [EXP_W+1:0] v);
    if (v >= E_OVF) begin
      return EXP_ONES;
    end else if (v <= E_ZERO) begin
      return '0;
    end else begin
      return v[EXP_W-1:0];
    end
  endfunction

  always_comb begin
    c_exp = sat_exp(e);
    flags = '0;
    if ((za | zb) & (ia | ib)) begin
      c_exp     = EXP_ONES;
      flags.nan = 1'b1;
    end else if (ia | ib) begin
      c_exp     = EXP_ONES;
      flags.inf = 1'b1;
    end else if (za | zb) begin
      c_exp      = '0;
      flags.zero = 1'b1;
    end else if (e >= E_OVF) begin
      flags.ovf = 1'b1;
    end else if (e <= E_ZERO) begin
      flags.unf = 1'b1;
    end
  end

endmodule

// File: rtl/fp_exp_sign_pipe.sv
// Two-stage exponent/sign pipe with valid/ready flow control (no skid buffer).
// Optional sticky status flags: define FP_EXP_STICKY_FLAGS_EN.
module fp_exp_sign_pipe
  import fp_exp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int BIAS  = 127
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [EXP_W-1:0] b_exp,
  input  logic             a_s,
  input  logic             b_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] c_exp,
  output logic             c_s,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_zero,
  output logic             out_inf,
  output logic             out_nan
`ifdef FP_EXP_STICKY_FLAGS_EN
  ,
  input  logic               sts_clr,
  output logic [NUM_FLG-1:0] sts_flags
`endif
);

  localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(exp_max(EXP_W));

  logic adv1, adv2;

  logic             vld_p1_d, vld_p1_q;
  logic [EXP_W:0]   sum_p1_d, sum_p1_q;
  logic             sgn_p1_d, sgn_p1_q;
  logic             za_p1_d, za_p1_q, zb_p1_d, zb_p1_q;
  logic             ia_p1_d, ia_p1_q, ib_p1_d, ib_p1_q;

  logic             vld_p2_d, vld_p2_q;
  logic [EXP_W-1:0] c_exp_p2_d, c_exp_p2_q;
  logic             c_s_p2_d, c_s_p2_q;
  fp_flags_t        flg_p2_d, flg_p2_q;

  logic [EXP_W-1:0] cls_exp;
  fp_flags_t        cls_flg;

  assign adv2     = ~vld_p2_q | out_ready;
  assign adv1     = ~vld_p1_q | adv2;
  assign in_ready = adv1;

  fp_exp_classify #(
    .EXP_W (EXP_W),
    .BIAS  (BIAS)
  ) u_classify (
    .sum   (sum_p1_q),
    .za    (za_p1_q),
    .zb    (zb_p1_q),
    .ia    (ia_p1_q),
    .ib    (ib_p1_q),
    .c_exp (cls_exp),
    .flags (cls_flg)
  );

  always_comb begin
    // S1: operand sum, sign and special-value detection
    vld_p1_d = vld_p1_q;
    sum_p1_d = sum_p1_q;
    sgn_p1_d = sgn_p1_q;
    za_p1_d  = za_p1_q;
    zb_p1_d  = zb_p1_q;
    ia_p1_d  = ia_p1_q;
    ib_p1_d  = ib_p1_q;
    if (adv1) begin
      vld_p1_d = in_valid;
      if (in_valid) begin
        sum_p1_d = {1'b0, a_exp} + {1'b0, b_exp};
        sgn_p1_d = a_s ^ b_s;
        za_p1_d  = (a_exp == '0);
        zb_p1_d  = (b_exp == '0);
        ia_p1_d  = (a_exp == EXP_ONES);
        ib_p1_d  = (b_exp == EXP_ONES);
      end
    end

    // S2: classified result, held while the consumer stalls
    vld_p2_d   = vld_p2_q;
    c_exp_p2_d = c_exp_p2_q;
    c_s_p2_d   = c_s_p2_q;
    flg_p2_d   = flg_p2_q;
    if (adv2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        c_exp_p2_d = cls_exp;
        c_s_p2_d   = sgn_p1_q;
        flg_p2_d   = cls_flg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      sum_p1_q   <= '0;
      sgn_p1_q   <= 1'b0;
      za_p1_q    <= 1'b0;
      zb_p1_q    <= 1'b0;
      ia_p1_q    <= 1'b0;
      ib_p1_q    <= 1'b0;
      vld_p2_q   <= 1'b0;
      c_exp_p2_q <= '0;
      c_s_p2_q   <= 1'b0;
      flg_p2_q   <= '0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      sum_p1_q   <= sum_p1_d;
      sgn_p1_q   <= sgn_p1_d;
      za_p1_q    <= za_p1_d;
      zb_p1_q    <= zb_p1_d;
      ia_p1_q    <= ia_p1_d;
      ib_p1_q    <= ib_p1_d;
      vld_p2_q   <= vld_p2_d;
      c_exp_p2_q <= c_exp_p2_d;
      c_s_p2_q   <= c_s_p2_d;
      flg_p2_q   <= flg_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign c_exp     = c_exp_p2_q;
  assign c_s       = c_s_p2_q;
  assign out_ovf   = flg_p2_q[FLG_OVF];
  assign out_unf   = flg_p2_q[FLG_UNF];
  assign out_zero  = flg_p2_q[FLG_ZERO];
  assign out_inf   = flg_p2_q[FLG_INF];
  assign out_nan   = flg_p2_q[FLG_NAN];

`ifdef FP_EXP_STICKY_FLAGS_EN
  logic [NUM_FLG-1:0] sts_d, sts_q;

  // A flag arriving with the clear wins, so no event is ever lost.
  always_comb begin
    sts_d = sts_clr ? '0 : sts_q;
    if (vld_p2_q & out_ready) begin
      sts_d = sts_d | flg_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sts_q <= '0;
    end else begin
      sts_q <= sts_d;
    end
  end

  assign sts_flags = sts_q;
`endif

endmodule

// File: tb/tb_fp_exp_sign_pipe.sv
// Directed self-checking bench for fp_exp_sign_pipe (EXP_W=8, BIAS=127).
module tb_fp_exp_sign_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a_exp = '0;
  logic [7:0] b_exp = '0;
  logic       a_s = 1'b0;
  logic       b_s = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] c_exp;
  logic       c_s;
  logic       out_ovf, out_unf, out_zero, out_inf, out_nan;
`ifdef FP_EXP_STICKY_FLAGS_EN
  logic       sts_clr = 1'b0;
  logic [4:0] sts_flags;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Hand-computed vectors: {nan,inf,zero,unf,ovf} in vf.
  logic [7:0] va [10] = '{8'd130, 8'd200, 8'd60, 8'd64, 8'd0,
                          8'd255, 8'd0,   8'd200, 8'd200, 8'd64};
  logic [7:0] vb [10] = '{8'd125, 8'd200, 8'd60, 8'd63, 8'd200,
                          8'd10,  8'd255, 8'd181, 8'd182, 8'd64};
  logic       vas[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       vbs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] ve [10] = '{8'h80, 8'hFF, 8'h00, 8'h00, 8'h00,
                          8'hFF, 8'hFF, 8'hFE, 8'hFF, 8'h01};
  logic       vs [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [4:0] vf [10] = '{5'b00000, 5'b00001, 5'b00010, 5'b00010, 5'b00100,
                          5'b01000, 5'b10000, 5'b00000, 5'b00001, 5'b00000};

  fp_exp_sign_pipe #(
    .EXP_W (8),
    .BIAS  (127)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_exp     (a_exp),
    .b_exp     (b_exp),
    .a_s       (a_s),
    .b_s       (b_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_exp     (c_exp),
    .c_s       (c_s),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .out_zero  (out_zero),
    .out_inf   (out_inf),
    .out_nan   (out_nan)
`ifdef FP_EXP_STICKY_FLAGS_EN
    ,
    .sts_clr   (sts_clr),
    .sts_flags (sts_flags)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] flags();
    return {out_nan, out_inf, out_zero, out_unf, out_ovf};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i);
    a_exp = va[i];
    b_exp = vb[i];
    a_s   = vas[i];
    b_s   = vbs[i];
  endtask

  // One isolated pair with out_ready high: checks the 2-cycle latency and result.
  task automatic run_one(input int i);
    @(posedge clk); #1;
    drive(i);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("lat1_v%0d", i), 32'(out_valid), 32'd0);
    @(negedge clk);
    chk($sformatf("lat2_v%0d", i), 32'(out_valid), 32'd1);
    chk($sformatf("exp_v%0d", i), 32'(c_exp), 32'(ve[i]));
    chk($sformatf("sgn_v%0d", i), 32'(c_s), 32'(vs[i]));
    chk($sformatf("flg_v%0d", i), 32'(flags()), 32'(vf[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, recv;
    logic held;
    logic [7:0] h_exp;
    logic [4:0] h_flg;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c_exp", 32'(c_exp), 32'd0);
    chk("rst_flags", 32'(flags()), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_one(i);

    // Backpressure stream: out_ready low in cycles 3..6
    @(posedge clk); #1;
    @(negedge clk);
    sent = 0;
    recv = 0;
    held = 1'b0;
    h_exp = '0;
    h_flg = '0;
    for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 6);
      if (sent < 6) drive(sent);
      @(negedge clk);
      if (cyc == 3) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (out_valid && held) begin
        chk("bp_hold_exp", 32'(c_exp), 32'(h_exp));
        chk("bp_hold_flg", 32'(flags()), 32'(h_flg));
      end
      if (out_valid && !out_ready) begin
        held  = 1'b1;
        h_exp = c_exp;
        h_flg = flags();
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp_exp_%0d", recv), 32'(c_exp), 32'(ve[recv]));
        chk($sformatf("bp_sgn_%0d", recv), 32'(c_s), 32'(vs[recv]));
        chk($sformatf("bp_flg_%0d", recv), 32'(flags()), 32'(vf[recv]));
        recv++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_recv_count", 32'(recv), 32'd6);
    @(negedge clk);
    chk("bp_no_extra", 32'(out_valid), 32'd0);

    // Reset with two items in flight
    @(posedge clk); #1;
    drive(0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_exp", 32'(c_exp), 32'd0);
    chk("mid_rst_sgn", 32'(c_s), 32'd0);
    chk("mid_rst_flg", 32'(flags()), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(8);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("post_rst_lat2", 32'(out_valid), 32'd1);
    chk("post_rst_exp", 32'(c_exp), 32'hFF);
    chk("post_rst_flg", 32'(flags()), 32'b00001);
    @(negedge clk);
    chk("post_rst_drain", 32'(out_valid), 32'd0);

`ifdef FP_EXP_STICKY_FLAGS_EN
    @(posedge clk); #1;
    sts_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sts_clr = 1'b0;
    @(negedge clk);
    chk("sts_cleared", 32'(sts_flags), 32'd0);
    run_one(1);
    run_one(2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sts_ovf_unf", 32'(sts_flags), 32'b00011);
    run_one(5);
    sts_clr = 1'b1;
    @(posedge clk); #1;
    sts_clr = 1'b0;
    @(negedge clk);
    chk("sts_clr_vs_inf", 32'(sts_flags), 32'b01000);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
